// File: rtl/lat_mem_responder.sv
// Fixed-latency word memory responder for a stalling data-memory interface.
// Optional one-entry read buffer enabled by defining RDBUF_EN.
module lat_mem_responder #(
    parameter int ADDR_W  = 10,
    parameter int DATA_W  = 32,
    parameter int DEPTH   = 256,
    parameter int LATENCY = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              mem_read,
    input  logic              mem_write,
    input  logic [ADDR_W-1:0] WordAddress,
    input  logic [DATA_W-1:0] DataIn,
    output logic              stall,
    output logic [DATA_W-1:0] DataOut,
    output logic [3:0]        busy_cnt
);

    localparam int IDX_W = ADDR_W - 2;
    // BUSY is entered one cycle after acceptance and exits one cycle early into DONE.
    localparam logic [3:0] CNT_INIT = 4'((LATENCY > 1) ? (LATENCY - 2) : 0);

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    state_t            state;
    logic [3:0]        cnt;
    logic [IDX_W-1:0]  idx_reg;
    logic [DATA_W-1:0] data_reg;
    logic              wr_reg;
    logic [DATA_W-1:0] dout_reg;
    logic [DATA_W-1:0] mem [DEPTH];

    logic              req;
    logic              hit;
    logic [IDX_W-1:0]  idx_in;
    logic [IDX_W-1:0]  rd_idx;

    assign req    = mem_read | mem_write;
    assign idx_in = WordAddress[ADDR_W-1:2];
    // With single-cycle latency the read happens on the accepting edge itself.
    assign rd_idx = (LATENCY == 1) ? idx_in : idx_reg;

`ifdef RDBUF_EN
    logic              buf_valid;
    logic [IDX_W-1:0]  buf_idx;
    logic [DATA_W-1:0] buf_data;

    assign hit = (state == IDLE) && mem_read && !mem_write && buf_valid && (buf_idx == idx_in);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            buf_valid <= 1'b0;
            buf_idx   <= '0;
            buf_data  <= '0;
        end else if (state == DONE) begin
            if (!wr_reg) begin
                buf_valid <= 1'b1;
                buf_idx   <= idx_reg;
                buf_data  <= dout_reg;
            end else if (buf_idx == idx_reg) begin
                buf_valid <= 1'b0;
            end
        end
    end

    assign DataOut = hit ? buf_data : dout_reg;
`else
    assign hit     = 1'b0;
    assign DataOut = dout_reg;
`endif

    assign stall    = reset & req & (state != DONE) & ~hit;
    assign busy_cnt = (state == BUSY) ? cnt : 4'd0;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state    <= IDLE;
            cnt      <= 4'd0;
            idx_reg  <= '0;
            data_reg <= '0;
            wr_reg   <= 1'b0;
            dout_reg <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (req && !hit) begin
                        idx_reg  <= idx_in;
                        data_reg <= DataIn;
                        wr_reg   <= mem_write;
                        if (LATENCY == 1) begin
                            state <= DONE;
                            if (!mem_write) dout_reg <= mem[rd_idx];
                        end else begin
                            state <= BUSY;
                            cnt   <= CNT_INIT;
                        end
                    end
                end
                BUSY: begin
                    if (!req) begin
                        // Core dropped the request early: abandon without side effects.
                        state <= IDLE;
                        cnt   <= 4'd0;
                    end else if (cnt == 4'd0) begin
                        state <= DONE;
                        if (!wr_reg) dout_reg <= mem[rd_idx];
                    end else begin
                        cnt <= cnt - 4'd1;
                    end
                end
                DONE:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    // A reset during DONE forces IDLE asynchronously, so the write is discarded.
    always_ff @(posedge clk) begin
        if (state == DONE && wr_reg) mem[idx_reg] <= data_reg;
    end

endmodule

// File: tb/tb_lat_mem_responder.sv
// Self-checking bench for lat_mem_responder: vector table, corner sequences,
// and randomized traffic against a word-array reference model.
module tb_lat_mem_responder;

    localparam int LAT = 4;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        mem_read = 1'b0;
    logic        mem_write = 1'b0;
    logic [9:0]  WordAddress = '0;
    logic [31:0] DataIn = '0;
    logic        stall;
    logic [31:0] DataOut;
    logic [3:0]  busy_cnt;

    lat_mem_responder #(
        .ADDR_W(10), .DATA_W(32), .DEPTH(256), .LATENCY(LAT)
    ) dut (
        .clk(clk), .reset(reset), .mem_read(mem_read), .mem_write(mem_write),
        .WordAddress(WordAddress), .DataIn(DataIn),
        .stall(stall), .DataOut(DataOut), .busy_cnt(busy_cnt)
    );

    always #5 clk = ~clk;

    int total = 0;
    int passed = 0;

    // Reference model: word contents plus the last-read word the buffer would hold.
    logic [31:0] model_mem [256];
    bit          buf_v = 1'b0;
    int          buf_i = 0;

    typedef struct {
        bit          wr;
        logic [9:0]  addr;
        logic [31:0] data;
        int          exp_cyc;
        logic [31:0] exp_data;
    } vec_t;

    vec_t vecs [6];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    endtask

    function automatic int exp_cycles(input bit wr, input int idx);
`ifdef RDBUF_EN
        if (!wr && buf_v && buf_i == idx) return 0;
`endif
        return LAT;
    endfunction

    task automatic model_apply(input bit wr, input int idx, input logic [31:0] d);
        if (wr) begin
            model_mem[idx] = d;
            if (buf_i == idx) buf_v = 1'b0;
        end else begin
            buf_v = 1'b1;
            buf_i = idx;
        end
    endtask

    // Presents a request at a negedge and holds it until stall is seen low.
    task automatic access(input bit wr, input logic [9:0] addr, input logic [31:0] d,
                          output int ncyc, output logic [31:0] dout);
        @(negedge clk);
        mem_write   = wr;
        mem_read    = !wr;
        WordAddress = addr;
        DataIn      = d;
        #1;
        ncyc = 0;
        while (stall === 1'b1 && ncyc < 64) begin
            ncyc++;
            @(negedge clk);
            #1;
        end
        dout = DataOut;
    endtask

    task automatic idle();
        @(negedge clk);
        mem_read  = 1'b0;
        mem_write = 1'b0;
    endtask

    task automatic run_txn(input string tag, input bit wr, input logic [9:0] addr, input logic [31:0] d);
        int          n;
        int          idx;
        int          expc;
        logic [31:0] q;
        idx  = int'(addr[9:2]);
        expc = exp_cycles(wr, idx);
        access(wr, addr, d, n, q);
        $display("%s %s addr=0x%03h data=0x%08h stall_cycles=%0d dout=0x%08h",
                 tag, wr ? "WR" : "RD", addr, d, n, q);
        check({tag, " cycles"}, 32'(n), 32'(expc));
        if (!wr) check({tag, " data"}, q, model_mem[idx]);
        model_apply(wr, idx, d);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int          n;
        logic [31:0] q;
        logic [9:0]  ra;
        bit          rw;

        vecs[0] = '{1'b1, 10'h010, 32'hDEADBEEF, LAT, 32'h0};
        vecs[1] = '{1'b0, 10'h010, 32'h0,        LAT, 32'hDEADBEEF};
        vecs[2] = '{1'b1, 10'h004, 32'h11111111, LAT, 32'h0};
        vecs[3] = '{1'b1, 10'h008, 32'h22222222, LAT, 32'h0};
        vecs[4] = '{1'b0, 10'h004, 32'h0,        LAT, 32'h11111111};
        vecs[5] = '{1'b0, 10'h008, 32'h0,        LAT, 32'h22222222};

        // Reset for three cycles, then idle outputs.
        repeat (3) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        #1;
        $display("RESET released stall=%0b dout=0x%08h busy_cnt=%0d", stall, DataOut, busy_cnt);
        check("reset stall", 32'(stall), 32'h0);
        check("reset dout", DataOut, 32'h0);
        check("reset busy_cnt", 32'(busy_cnt), 32'h0);

        // Back-to-back table vectors.
        for (int i = 0; i < 6; i++) begin
            access(vecs[i].wr, vecs[i].addr, vecs[i].data, n, q);
            $display("VEC%0d %s addr=0x%03h data=0x%08h stall_cycles=%0d dout=0x%08h",
                     i, vecs[i].wr ? "WR" : "RD", vecs[i].addr, vecs[i].data, n, q);
            check($sformatf("vec%0d cycles", i), 32'(n), 32'(vecs[i].exp_cyc));
            if (!vecs[i].wr) check($sformatf("vec%0d data", i), q, vecs[i].exp_data);
            model_apply(vecs[i].wr, int'(vecs[i].addr[9:2]), vecs[i].data);
        end
        idle();

        // busy_cnt walk through a single write.
        @(negedge clk);
        mem_write = 1'b1; WordAddress = 10'h0A0; DataIn = 32'h0A0A0A0A;
        for (int c = 0; c <= LAT; c++) begin
            #1;
            $display("BUSYWALK cycle=%0d stall=%0b busy_cnt=%0d", c, stall, busy_cnt);
            check($sformatf("walk%0d stall", c), 32'(stall), (c < LAT) ? 32'h1 : 32'h0);
            check($sformatf("walk%0d busy_cnt", c), 32'(busy_cnt),
                  (c >= 1 && c < LAT) ? 32'(LAT - 1 - c) : 32'h0);
            @(negedge clk);
        end
        mem_write = 1'b0;
        model_apply(1'b1, 10'h0A0 >> 2, 32'h0A0A0A0A);

        // Reset during a write: stall drops at once, old contents survive.
        run_txn("PRE-RST", 1'b1, 10'h020, 32'h12345678);
        @(negedge clk);
        mem_write = 1'b1; mem_read = 1'b0; WordAddress = 10'h020; DataIn = 32'hCAFEF00D;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        #1;
        $display("MIDRST stall=%0b busy_cnt=%0d", stall, busy_cnt);
        check("midreset stall", 32'(stall), 32'h0);
        check("midreset busy_cnt", 32'(busy_cnt), 32'h0);
        @(negedge clk);
        mem_write = 1'b0;
        reset = 1'b1;
        buf_v = 1'b0;
        #1;
        check("postreset dout", DataOut, 32'h0);
        run_txn("POST-RST", 1'b0, 10'h020, 32'h0);

        // Request dropped mid-access: access abandoned, no write.
        run_txn("PRE-ABT", 1'b1, 10'h0C0, 32'hA5A5A5A5);
        @(negedge clk);
        mem_write = 1'b1; mem_read = 1'b0; WordAddress = 10'h0C0; DataIn = 32'h5A5A5A5A;
        @(negedge clk);
        mem_write = 1'b0;
        #1;
        check("abort stall", 32'(stall), 32'h0);
        @(negedge clk);
        #1;
        $display("ABORT busy_cnt=%0d", busy_cnt);
        check("abort busy_cnt", 32'(busy_cnt), 32'h0);
        run_txn("POST-ABT", 1'b0, 10'h0C0, 32'h0);

        // Address/data change after acceptance is ignored.
        run_txn("ADDR-SETUP", 1'b1, 10'h030, 32'h30303030);
        run_txn("ADDR-SETUP", 1'b1, 10'h040, 32'h40404040);
        @(negedge clk);
        mem_read = 1'b1; mem_write = 1'b0; WordAddress = 10'h030; DataIn = 32'h0;
        #1;
        n = 0;
        while (stall === 1'b1 && n < 64) begin
            n++;
            @(negedge clk);
            if (n == 2) begin
                WordAddress = 10'h040;
                DataIn      = 32'hFFFFFFFF;
            end
            #1;
        end
        $display("ADDRCHG RD addr=0x030->0x040 stall_cycles=%0d dout=0x%08h", n, DataOut);
        check("addrchg cycles", 32'(n), 32'(LAT));
        check("addrchg data", DataOut, 32'h30303030);
        model_apply(1'b0, 10'h030 >> 2, 32'h0);
        idle();

        // Repeated read, then write and read of the same word.
        run_txn("RDBUF", 1'b1, 10'h050, 32'h55AA55AA);
        run_txn("RDBUF", 1'b0, 10'h050, 32'h0);
        run_txn("RDBUF", 1'b0, 10'h050, 32'h0);
        run_txn("RDBUF", 1'b1, 10'h050, 32'h0BADF00D);
        run_txn("RDBUF", 1'b0, 10'h050, 32'h0);
        idle();

        // Randomized traffic over four words, ignored low address bits, random gaps.
        for (int i = 0; i < 4; i++)
            run_txn("RND-INIT", 1'b1, 10'((10'h60 + i) << 2), $urandom);
        for (int t = 0; t < 40; t++) begin
            rw = ($urandom_range(0, 2) == 0);
            ra = 10'(((10'h60 + $urandom_range(0, 3)) << 2) | $urandom_range(0, 3));
            run_txn($sformatf("RND%0d", t), rw, ra, $urandom);
            if ($urandom_range(0, 2) == 0) begin
                idle();
                repeat ($urandom_range(0, 2)) @(negedge clk);
            end
        end
        idle();

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/lat_mem_responder.md
Name: lat_mem_responder

Overview:
- Responder end of the core's stalling data-memory interface (mem_read / mem_write / WordAddress / DataIn -> stall / DataOut).
- Word-organised backing memory with fixed, parameterised access latency. Holds `stall` high until each access completes, so the single-cycle core freezes PC and register writeback meanwhile.
- Drop-in alternative responder for latency and stall testing of the core.

Parameters:
- ADDR_W, 10, width of WordAddress (byte address); word index = WordAddress[ADDR_W-1:2]
- DATA_W, 32, data width
- DEPTH, 256, number of words; must equal 2**(ADDR_W-2)
- LATENCY, 4, stall cycles per access; legal range 1..15

Ports:
- clk  input  1  rising-edge clock
- reset  input  1  asynchronous, active-low reset (0 = reset)
- mem_read  input  1  read request, held by the core until stall is low
- mem_write  input  1  write request, held by the core until stall is low
- WordAddress  input  ADDR_W  byte address; bits [1:0] ignored
- DataIn  input  DATA_W  write data
- stall  output  1  high = access in progress, core must freeze
- DataOut  output  DATA_W  read data; valid in the cycle stall falls
- busy_cnt  output  4  remaining latency count, debug only

Behaviour:
- Reset (reset=0, async):
  - state=IDLE, cnt=0, DataOut reg=0, latched addr/data=0.
  - stall is 0 while idle with no request.
  - Memory array is not cleared.
- req = mem_read | mem_write. When both are high, write wins; DataOut holds its previous value.
- stall is combinational: stall = req & (state != DONE).
- States:
  - IDLE, req=1:
    - latch word index, DataIn and op.
    - If LATENCY==1, go to DONE. Otherwise go to BUSY with cnt=LATENCY-2.
  - IDLE, req=0: stay in IDLE.
  - BUSY, req=1: if cnt==0 go to DONE, else cnt decrements.
  - BUSY, req=0 (protocol violation): abort and return to IDLE. No write, DataOut unchanged.
  - On entry to DONE for a read: DataOut reg <= mem[latched index].
  - DONE:
    - stall=0 and DataOut is valid.
    - A write commits mem[latched index] <= latched data at the DONE clock edge.
    - Next state is always IDLE.
- Timing: request first visible in cycle 0 -> stall high in cycles 0..LATENCY-1 -> stall low in cycle LATENCY. The core advances at the end of cycle LATENCY.
- Back-to-back: a new request in the cycle after DONE starts a fresh access from IDLE. No request is lost and no extra bubble is added.
- Address, data and op are taken from the latched copies. Changes on the inputs after acceptance are ignored.
- Reset asserted mid-access: immediately IDLE, stall drops, the pending write is discarded.
- busy_cnt = cnt in BUSY, else 0.

Optional Feature:
- Macro: RDBUF_EN.
- Defined:
  - One-entry read buffer (valid, index, data).
  - Loaded on every completed read in DONE. Cleared by reset and by any committed write whose index matches.
  - A read request in IDLE whose index matches a valid entry is a hit:
    - stall=0 in the same cycle.
    - DataOut = buffered data (combinational mux).
    - state stays IDLE and no latency is incurred.
  - A write never hits.
- Undefined: no buffer logic; every read costs LATENCY stall cycles. DataOut is always the registered value.

Test Plan:
- Reset (reset=0, 3 cycles) then release, no request -> stall=0, DataOut=0, busy_cnt=0.
- LATENCY=4: write 0xDEADBEEF to WordAddress=0x010, then read 0x010 -> each access stall=1 for exactly 4 cycles, read gives DataOut=0xDEADBEEF in cycle 4.
- Back-to-back writes to 0x004 (0x11111111) then 0x008 (0x22222222), then reads of both -> correct values, 4 stall cycles each, no extra idle cycle between accesses.
- Assert reset for 1 cycle at cycle 2 of a write of 0xCAFEF00D to 0x020, then read 0x020 -> old contents returned, stall dropped on reset.
- WordAddress changed from 0x030 to 0x040 during BUSY of a read -> data from 0x030 returned.
- RDBUF_EN: read 0x050 (4 stall cycles), read 0x050 again -> stall=0, same data. Then write 0x050 and read 0x050 -> 4 stall cycles, new data returned.
